// File: rtl/dram_fe_pkg.sv
// Shared types and default widths for the DRAM host-request front end.
// The localparams here are the default configuration of the block.
package dram_fe_pkg;

  localparam int FE_ADDR_W = 24;
  localparam int FE_DATA_W = 64;
  localparam int FE_ID_W   = 4;
  localparam int FE_DEPTH  = 8;
  localparam int FE_CNT_W  = 16;
  localparam int FE_PTR_W  = $clog2(FE_DEPTH) + 1;

  typedef struct packed {
    logic                 write;
    logic [FE_ADDR_W-1:0] addr;
    logic [FE_ID_W-1:0]   id;
    logic [FE_DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  typedef logic [FE_CNT_W-1:0] cnt_t;

  // Pointer width carries one extra wrap bit above the slot index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dram_req_frontend_if.sv
// Host request, controller command and forward-return signals of the front end.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
interface dram_req_frontend_if
  import dram_fe_pkg::*;
#(
    parameter int ADDR_W = FE_ADDR_W,
    parameter int DATA_W = FE_DATA_W,
    parameter int ID_W   = FE_ID_W
) ();

    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_write;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_wdata;
    logic [ID_W-1:0]   i_req_id;

    logic              o_cmd_valid;
    logic              i_cmd_ready;
    logic              o_cmd_write;
    logic [ADDR_W-1:0] o_cmd_addr;
    logic [DATA_W-1:0] o_cmd_wdata;
    logic [ID_W-1:0]   o_cmd_id;

    logic              o_fwd_valid;
    logic [DATA_W-1:0] o_fwd_data;
    logic [ID_W-1:0]   o_fwd_id;

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_id, i_cmd_ready,
        output o_req_ready, o_cmd_valid, o_cmd_write, o_cmd_addr, o_cmd_wdata, o_cmd_id,
        output o_fwd_valid, o_fwd_data, o_fwd_id
    );

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_id, i_cmd_ready,
        input  o_req_ready, o_cmd_valid, o_cmd_write, o_cmd_addr, o_cmd_wdata, o_cmd_id,
        input  o_fwd_valid, o_fwd_data, o_fwd_id
    );

endinterface

// File: rtl/dram_fe_match.sv
// Youngest-write search over the request ring: scans from tail-1 backward
// (modulo DEPTH) and reports the first valid write whose address matches.
module dram_fe_match #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 24,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             ent_valid_i,
    input  logic [DEPTH-1:0]             ent_write_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_i,
    input  logic [IDX_W-1:0]             tail_i,
    input  logic [ADDR_W-1:0]            addr_i,
    output logic                         hit_o,
    output logic [IDX_W-1:0]             idx_o
);

    logic [IDX_W-1:0] idx;

    // Oldest slot is visited first so that younger hits overwrite it.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        idx   = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail_i - IDX_W'(i);
            if (ent_valid_i[idx] && ent_write_i[idx] && (ent_addr_i[idx] == addr_i)) begin
                hit_o = 1'b1;
                idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/dram_req_frontend.sv
// Host-side request queue for the DRAM controller with read-after-write
// forwarding from queued writes and accept/forward statistics.
module dram_req_frontend
  import dram_fe_pkg::*;
#(
    parameter int ADDR_W = FE_ADDR_W,
    parameter int DATA_W = FE_DATA_W,
    parameter int ID_W   = FE_ID_W,
    parameter int DEPTH  = FE_DEPTH,
    parameter int CNT_W  = FE_CNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    dram_req_frontend_if.slave bus,
    output logic [CNT_W-1:0]   o_wr_cnt,
    output logic [CNT_W-1:0]   o_rd_cnt,
    output logic [CNT_W-1:0]   o_raw_cnt
);

    localparam int PW = ptr_width(DEPTH);
    localparam int IW = PW - 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [DEPTH-1:0]             write_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] wdata_q;
    logic [DEPTH-1:0][ID_W-1:0]   id_q;

    logic              fwd_valid_q, fwd_valid_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [ID_W-1:0]   fwd_id_q, fwd_id_d;

    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] raw_cnt_q, raw_cnt_d;

    logic [IW-1:0]    wr_idx, rd_idx, ent_off, hit_idx;
    logic [PW-1:0]    count;
    logic [DEPTH-1:0] ent_valid;
    logic             full, empty, accept, pop, push, fwd, hit;

    assign wr_idx = wr_ptr_q[IW-1:0];
    assign rd_idx = rd_ptr_q[IW-1:0];
    assign count  = wr_ptr_q - rd_ptr_q;
    assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
    assign empty  = (wr_ptr_q == rd_ptr_q);

    // A slot is live when its distance from the head is below the occupancy;
    // the head stays live in a popping cycle so it can still forward.
    always_comb begin
        ent_valid = '0;
        ent_off   = '0;
        for (int j = 0; j < DEPTH; j++) begin
            ent_off      = IW'(j) - rd_idx;
            ent_valid[j] = ({1'b0, ent_off} < count);
        end
    end

    dram_fe_match #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .IDX_W (IW)
    ) u_match (
        .ent_valid_i(ent_valid),
        .ent_write_i(write_q),
        .ent_addr_i (addr_q),
        .tail_i     (wr_idx),
        .addr_i     (bus.i_req_addr),
        .hit_o      (hit),
        .idx_o      (hit_idx)
    );

    assign accept = bus.i_req_valid && !full;
    assign pop    = !empty && bus.i_cmd_ready;
    assign fwd    = accept && !bus.i_req_write && hit;
    assign push   = accept && !fwd;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fwd_valid_d = fwd;
        fwd_data_d  = fwd_data_q;
        fwd_id_d    = fwd_id_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        raw_cnt_d   = raw_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (fwd) begin
            fwd_data_d = wdata_q[hit_idx];
            fwd_id_d   = bus.i_req_id;
            raw_cnt_d  = raw_cnt_q + CNT_W'(1);
        end
        if (accept) begin
            if (bus.i_req_write) wr_cnt_d = wr_cnt_q + CNT_W'(1);
            else                 rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            write_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            id_q        <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
            fwd_id_q    <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            raw_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_data_q  <= fwd_data_d;
            fwd_id_q    <= fwd_id_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            raw_cnt_q   <= raw_cnt_d;
            if (push) begin
                write_q[wr_idx] <= bus.i_req_write;
                addr_q[wr_idx]  <= bus.i_req_addr;
                wdata_q[wr_idx] <= bus.i_req_wdata;
                id_q[wr_idx]    <= bus.i_req_id;
            end
        end
    end

    assign bus.o_req_ready = !full;
    assign bus.o_cmd_valid = !empty;
    assign bus.o_cmd_write = write_q[rd_idx];
    assign bus.o_cmd_addr  = addr_q[rd_idx];
    assign bus.o_cmd_wdata = wdata_q[rd_idx];
    assign bus.o_cmd_id    = id_q[rd_idx];
    assign bus.o_fwd_valid = fwd_valid_q;
    assign bus.o_fwd_data  = fwd_data_q;
    assign bus.o_fwd_id    = fwd_id_q;

    assign o_wr_cnt  = wr_cnt_q;
    assign o_rd_cnt  = rd_cnt_q;
    assign o_raw_cnt = raw_cnt_q;

endmodule

// File: tb/tb_dram_req_frontend.sv
// Directed and random stimulus for dram_req_frontend with a command/forward scoreboard.
module tb_dram_req_frontend;
  import dram_fe_pkg::*;

  localparam int DEPTH = FE_DEPTH;

  logic clk;
  logic rst_n;
  logic [FE_CNT_W-1:0] wr_cnt, rd_cnt, raw_cnt;

  dram_req_frontend_if bus ();

  dram_req_frontend dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .bus      (bus),
    .o_wr_cnt (wr_cnt),
    .o_rd_cnt (rd_cnt),
    .o_raw_cnt(raw_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [REQ_W-1:0]               exp_cmd_q[$];
  logic [FE_DATA_W+FE_ID_W-1:0]   exp_fwd_q[$];
  int wr_m = 0, rd_m = 0, raw_m = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 128'(bus.o_req_ready), 128'(1));
    chk({tag, "_cmd_valid"}, 128'(bus.o_cmd_valid), 128'(0));
    chk({tag, "_cmd_write"}, 128'(bus.o_cmd_write), 128'(0));
    chk({tag, "_cmd_addr"},  128'(bus.o_cmd_addr),  128'(0));
    chk({tag, "_cmd_wdata"}, 128'(bus.o_cmd_wdata), 128'(0));
    chk({tag, "_cmd_id"},    128'(bus.o_cmd_id),    128'(0));
    chk({tag, "_fwd_valid"}, 128'(bus.o_fwd_valid), 128'(0));
    chk({tag, "_fwd_data"},  128'(bus.o_fwd_data),  128'(0));
    chk({tag, "_fwd_id"},    128'(bus.o_fwd_id),    128'(0));
    chk({tag, "_cnts"},      128'({wr_cnt, rd_cnt, raw_cnt}), 128'(0));
  endtask

  // driver: one cycle; the model decides acceptance/forwarding from pre-edge state
  task automatic step(input bit v, input bit w, input logic [FE_ADDR_W-1:0] a,
                      input logic [FE_DATA_W-1:0] d, input logic [FE_ID_W-1:0] id,
                      input bit cr, output bit accepted);
    bit   hit;
    req_t e;
    logic [FE_DATA_W-1:0] hd;
    bus.i_req_valid = v;
    bus.i_req_write = w;
    bus.i_req_addr  = a;
    bus.i_req_wdata = d;
    bus.i_req_id    = id;
    bus.i_cmd_ready = cr;
    accepted = v && (exp_cmd_q.size() < DEPTH);
    hit = 1'b0;
    hd  = '0;
    if (accepted && !w) begin
      for (int k = exp_cmd_q.size() - 1; k >= 0; k--) begin
        e = req_t'(exp_cmd_q[k]);
        if (!hit && e.write && e.addr == a) begin
          hit = 1'b1;
          hd  = e.wdata;
        end
      end
    end
    @(posedge clk);
    if (accepted) begin
      if (w) wr_m++; else rd_m++;
      if (hit) begin
        raw_m++;
        exp_fwd_q.push_back({hd, id});
      end else begin
        e.write = w; e.addr = a; e.id = id; e.wdata = d;
        exp_cmd_q.push_back(REQ_W'(e));
      end
    end
    #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic idle(input bit cr);
    bit acc;
    step(1'b0, 1'b0, '0, '0, '0, cr, acc);
  endtask

  // scoreboard monitor, mid-cycle sampling
  always @(negedge clk) begin
    req_t obs;
    if (rst_n) begin
      chk("cmd_valid", 128'(bus.o_cmd_valid), 128'(exp_cmd_q.size() != 0));
      chk("req_ready", 128'(bus.o_req_ready), 128'(exp_cmd_q.size() != DEPTH));
      if (bus.o_cmd_valid && bus.i_cmd_ready && exp_cmd_q.size() != 0) begin
        obs.write = bus.o_cmd_write; obs.addr = bus.o_cmd_addr;
        obs.id = bus.o_cmd_id; obs.wdata = bus.o_cmd_wdata;
        chk("cmd_fields", 128'(obs), 128'(exp_cmd_q[0]));
        void'(exp_cmd_q.pop_front());
      end
      chk("fwd_valid", 128'(bus.o_fwd_valid), 128'(exp_fwd_q.size() != 0));
      if (exp_fwd_q.size() != 0) begin
        if (bus.o_fwd_valid) chk("fwd_fields", 128'({bus.o_fwd_data, bus.o_fwd_id}), 128'(exp_fwd_q[0]));
        void'(exp_fwd_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int acc_n, guard, base;
    rst_n = 1'b0;
    bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_addr = '0;
    bus.i_req_wdata = '0;   bus.i_req_id = '0;      bus.i_cmd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst_n = 1'b1;

    // basic RAW forward, queue keeps the write
    step(1, 1, 24'h10, 64'hAA, 4'd1, 0, acc);
    step(1, 0, 24'h10, 64'h0, 4'd2, 0, acc);
    chk("t1_fwd_pulse", 128'({bus.o_fwd_valid, bus.o_fwd_data, bus.o_fwd_id}), 128'({1'b1, 64'hAA, 4'd2}));
    idle(0);
    chk("t1_fwd_single", 128'(bus.o_fwd_valid), 128'(0));
    chk("t1_cnts", 128'({wr_cnt, rd_cnt, raw_cnt}), 128'({16'd1, 16'd1, 16'd1}));
    chk("t1_one_entry", 128'({bus.o_cmd_valid, bus.o_cmd_addr}), 128'({1'b1, 24'h10}));
    idle(1);
    idle(0);

    // youngest matching write wins
    step(1, 1, 24'h20, 64'h1, 4'd3, 0, acc);
    step(1, 1, 24'h20, 64'h2, 4'd4, 0, acc);
    step(1, 0, 24'h20, 64'h0, 4'd5, 0, acc);
    chk("t2_youngest", 128'({bus.o_fwd_valid, bus.o_fwd_data, bus.o_fwd_id}), 128'({1'b1, 64'h2, 4'd5}));
    idle(1); idle(1); idle(0);

    // read hits the head that issues in the same cycle
    step(1, 1, 24'h30, 64'h33, 4'd6, 0, acc);
    step(1, 0, 24'h30, 64'h0, 4'd7, 1, acc);
    chk("t3_head_fwd", 128'({bus.o_fwd_valid, bus.o_fwd_data, bus.o_fwd_id}), 128'({1'b1, 64'h33, 4'd7}));
    chk("t3_empty", 128'(bus.o_cmd_valid), 128'(0));
    chk("t3_cnts", 128'({wr_cnt, rd_cnt, raw_cnt}), 128'({16'd4, 16'd3, 16'd3}));
    idle(0);

    // fill, full, single pop, in-order drain
    for (int i = 0; i < DEPTH; i++)
      step(1, 1, 24'h100 + 24'(i), 64'(32'hD000 + i), 4'(i), 0, acc);
    chk("t4_full", 128'(bus.o_req_ready), 128'(0));
    step(1, 1, 24'h1FF, 64'h9, 4'd9, 1, acc);
    chk("t4_blocked_accept", 128'(acc), 128'(0));
    chk("t4_ready_again", 128'(bus.o_req_ready), 128'(1));
    repeat (DEPTH) idle(1);
    chk("t4_drained", 128'(bus.o_cmd_valid), 128'(0));
    chk("t4_wr_cnt", 128'(wr_cnt), 128'(12));

    // random mix
    base = wr_m + rd_m;
    acc_n = 0;
    guard = 0;
    while (acc_n < 500 && guard < 20000) begin
      step(1, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 7)), {$urandom, $urandom},
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), acc);
      if (acc) acc_n++;
      guard++;
    end
    chk("rand_accepted", 128'(acc_n), 128'(500));
    repeat (DEPTH + 2) idle(1);
    chk("rand_total", 128'(32'(wr_cnt) + 32'(rd_cnt) - 32'(base)), 128'(500));
    chk("rand_cnts", 128'({wr_cnt, rd_cnt, raw_cnt}), 128'({16'(wr_m), 16'(rd_m), 16'(raw_m)}));
    chk("rand_cmd_q_empty", 128'(exp_cmd_q.size()), 128'(0));

    // reset with queued entries and a forward pending
    for (int i = 0; i < 5; i++)
      step(1, 1, 24'h200 + 24'(i), 64'(i + 1), 4'(i), 0, acc);
    step(1, 0, 24'h202, 64'h0, 4'd12, 0, acc);
    chk("t6_pre_fwd", 128'(bus.o_fwd_valid), 128'(1));
    rst_n = 1'b0;
    exp_cmd_q.delete();
    exp_fwd_q.delete();
    wr_m = 0; rd_m = 0; raw_m = 0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0);
    chk("t6_after_release", 128'(bus.o_cmd_valid), 128'(0));
    chk("t6_fwd_dropped", 128'(bus.o_fwd_valid), 128'(0));
    chk("end_fwd_q_empty", 128'(exp_fwd_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
